// File: rtl/signed_or_unsigned_div.sv
`default_nettype none
// ============================================================================
// Module   : signed_or_unsigned_div
// Purpose  : Multi-cycle restoring divider. It handles one operation at a time
//            and produces an N-bit quotient and an N-bit remainder. A bit sent
//            with each request selects signed (two's-complement) or unsigned
//            operands. Quotient truncates toward zero; remainder takes the
//            dividend's sign.
// Ports    : clk         - clock, rising edge
//            rst         - synchronous active-high reset
//            arg_vld     - request valid
//            arg_rdy     - block idle, can accept a request
//            a, b        - dividend, divisor (N bits)
//            signed_div  - 1 = signed operands, 0 = unsigned
//            res_vld     - result valid (registered, == state DONE)
//            res_rdy     - consumer accepts the result
//            quo, rem    - quotient, remainder (N bits)
//            div_by_zero - result came from a zero divisor
// Revision : 1.0 - initial release
// ============================================================================
module signed_or_unsigned_div #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  output logic         arg_rdy,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_div,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [N-1:0] quo,
  output logic [N-1:0] rem,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
  localparam logic [CW-1:0] c_CNT_N   = CW'(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic          r_sa;        // dividend negative (signed mode only)
  logic          r_sb;        // divisor negative (signed mode only)
  logic          r_bz;        // divisor was zero at accept
  logic [N-1:0]  r_a_orig;    // original dividend pattern, returned on /0
  logic [N-1:0]  r_dvd;       // dividend magnitude shifting out, quotient shifting in
  logic [N-1:0]  r_bmag;      // divisor magnitude
  logic [N-1:0]  r_pr;        // partial remainder (always < |b|, so N bits hold it)
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_rem;
  logic          r_dz;
  logic          r_res_vld;

  logic          w_sa;
  logic          w_sb;
  logic [N:0]    w_shift;     // N+1-bit partial remainder after shift-in
  logic [N:0]    w_diff;
  logic          w_q_bit;
  logic [CW-1:0] w_cnt_inc;

  assign arg_rdy     = (r_state == S_IDLE);
  assign res_vld     = r_res_vld;
  assign quo         = r_quo;
  assign rem         = r_rem;
  assign div_by_zero = r_dz;

  assign w_sa      = a[N-1] & signed_div;
  assign w_sb      = b[N-1] & signed_div;
  assign w_shift   = {r_pr, r_dvd[N-1]};
  assign w_diff    = w_shift - {1'b0, r_bmag};
  // A borrow out of the trial subtraction means the divisor did not fit.
  assign w_q_bit   = ~w_diff[N];
  assign w_cnt_inc = r_cnt + c_CNT_ONE;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (arg_vld)             w_state_next = S_BUSY;
      S_BUSY: if (w_cnt_inc == c_CNT_N) w_state_next = S_FIX;
      S_FIX:                           w_state_next = S_DONE;
      S_DONE: if (res_rdy)             w_state_next = S_IDLE;
      default:                         w_state_next = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_bz      <= 1'b0;
      r_a_orig  <= '0;
      r_dvd     <= '0;
      r_bmag    <= '0;
      r_pr      <= '0;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dz      <= 1'b0;
      r_res_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arg_vld) begin
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_bz     <= (b == '0);
            r_a_orig <= a;
            // Negating smin yields smin, which is exactly its unsigned magnitude.
            r_dvd    <= w_sa ? -a : a;
            r_bmag   <= w_sb ? -b : b;
            r_pr     <= '0;
            r_cnt    <= '0;
          end
        end
        S_BUSY: begin
          r_pr  <= w_q_bit ? w_diff[N-1:0] : w_shift[N-1:0];
          r_dvd <= {r_dvd[N-2:0], w_q_bit};
          r_cnt <= w_cnt_inc;
        end
        S_FIX: begin
          if (r_bz) begin
            // A zero divisor leaves an all-ones quotient; report it without
            // sign correction and hand back the original dividend.
            r_quo <= '1;
            r_rem <= r_a_orig;
          end else begin
            r_quo <= (r_sa ^ r_sb) ? -r_dvd : r_dvd;
            r_rem <= r_sa ? -r_pr : r_pr;
          end
          r_dz      <= r_bz;
          r_res_vld <= 1'b1;
        end
        S_DONE: begin
          if (res_rdy) begin
            r_res_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_signed_or_unsigned_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_or_unsigned_div
// Purpose  : Self-checking bench for signed_or_unsigned_div. It runs an N=8
//            instance with directed and random operations and an N=4 instance
//            exhaustively. Results are checked against an integer-arithmetic
//            reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signed_or_unsigned_div;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // N = 8 instance
  logic       rst8, vld8, rdy8, sd8, rv8, rr8, dz8;
  logic [7:0] a8, b8, q8, r8;
  // N = 4 instance
  logic       rst4, vld4, rdy4, sd4, rv4, rr4, dz4;
  logic [3:0] a4, b4, q4, r4;

  int ncmp = 0;
  int nfail = 0;

  signed_or_unsigned_div #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst8), .arg_vld(vld8), .arg_rdy(rdy8), .a(a8), .b(b8),
    .signed_div(sd8), .res_vld(rv8), .res_rdy(rr8), .quo(q8), .rem(r8),
    .div_by_zero(dz8));

  signed_or_unsigned_div #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst4), .arg_vld(vld4), .arg_rdy(rdy4), .a(a4), .b(b4),
    .signed_div(sd4), .res_vld(rv4), .res_rdy(rr4), .quo(q4), .rem(r4),
    .div_by_zero(dz4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer / and %, with the zero-divisor rule on top.
  function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input bit sd, output logic [31:0] q,
                                  output logic [31:0] r, output bit dz);
    int ai, bi;
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    if (b == 0) begin
      q  = mask;
      r  = a;
      dz = 1'b1;
    end else begin
      ai = (sd && a[w-1]) ? int'(a) - (1 << w) : int'(a);
      bi = (sd && b[w-1]) ? int'(b) - (1 << w) : int'(b);
      q  = 32'(ai / bi) & mask;
      r  = 32'(ai % bi) & mask;
      dz = 1'b0;
    end
  endfunction

  // One complete operation on the N=8 instance. With stall>0 the result is
  // held for that many cycles while the request inputs are scrambled.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input bit tsd, input int stall);
    logic [31:0] eq, er;
    bit edz;
    int lat;
    ref_div(8, {24'd0, ta}, {24'd0, tb}, tsd, eq, er, edz);
    @(negedge clk);
    a8 = ta; b8 = tb; sd8 = tsd; vld8 = 1'b1; rr8 = (stall == 0);
    chk("arg_rdy_idle8", {31'd0, rdy8}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    vld8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    chk("arg_rdy_busy8", {31'd0, rdy8}, 32'd0);
    lat = 0;
    while (!rv8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency8", 32'(lat), 32'd9);
    chk("quo8", {24'd0, q8}, eq);
    chk("rem8", {24'd0, r8}, er);
    chk("dz8", {31'd0, dz8}, {31'd0, edz});
    for (int i = 0; i < stall; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sd8 = 1'($urandom); vld8 = 1'($urandom);
      @(negedge clk);
      chk("hold_vld8", {31'd0, rv8}, 32'd1);
      chk("hold_quo8", {24'd0, q8}, eq);
      chk("hold_rem8", {24'd0, r8}, er);
      chk("hold_rdy8", {31'd0, rdy8}, 32'd0);
    end
    vld8 = 1'b0; rr8 = 1'b1;
    @(negedge clk);
    chk("consumed_vld8", {31'd0, rv8}, 32'd0);
    chk("consumed_rdy8", {31'd0, rdy8}, 32'd1);
    rr8 = 1'b0;
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input bit tsd, input int stall);
    logic [31:0] eq, er;
    bit edz;
    int lat;
    ref_div(4, {28'd0, ta}, {28'd0, tb}, tsd, eq, er, edz);
    @(negedge clk);
    a4 = ta; b4 = tb; sd4 = tsd; vld4 = 1'b1; rr4 = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    vld4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (!rv4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency4", 32'(lat), 32'd5);
    chk($sformatf("quo4 %0h/%0h s%0d", ta, tb, tsd), {28'd0, q4}, eq);
    chk($sformatf("rem4 %0h/%0h s%0d", ta, tb, tsd), {28'd0, r4}, er);
    chk("dz4", {31'd0, dz4}, {31'd0, edz});
    repeat (stall) @(negedge clk);
    rr4 = 1'b1;
    @(negedge clk);
    chk("consumed_vld4", {31'd0, rv4}, 32'd0);
    rr4 = 1'b0;
  endtask

  initial begin
    rst8 = 1'b1; vld8 = 1'b0; rr8 = 1'b0; sd8 = 1'b0; a8 = '0; b8 = '0;
    rst4 = 1'b1; vld4 = 1'b0; rr4 = 1'b0; sd4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", {31'd0, rdy8}, 32'd1);
    chk("reset_vld", {31'd0, rv8}, 32'd0);
    chk("reset_quo", {24'd0, q8}, 32'd0);
    chk("reset_rem", {24'd0, r8}, 32'd0);
    chk("reset_dz", {31'd0, dz8}, 32'd0);
    rst8 = 1'b0; rst4 = 1'b0;

    // Directed cases
    run8(8'd200, 8'd7, 1'b0, 0);
    run8(8'hF9, 8'd2, 1'b1, 0);
    run8(8'd7, 8'hFE, 1'b1, 1);
    run8(8'hF9, 8'hFE, 1'b1, 0);
    run8(8'h80, 8'hFF, 1'b1, 0);
    run8(8'h80, 8'hFF, 1'b0, 2);
    run8(8'h55, 8'h00, 1'b0, 0);
    run8(8'h55, 8'h00, 1'b1, 0);
    // Backpressure: five held cycles, then a new request right after release
    run8(8'd123, 8'd5, 1'b0, 5);
    run8(8'd50, 8'd3, 1'b0, 0);

    // Reset three BUSY cycles into an operation
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd7; sd8 = 1'b0; vld8 = 1'b1; rr8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    chk("midrst_rdy", {31'd0, rdy8}, 32'd1);
    chk("midrst_vld", {31'd0, rv8}, 32'd0);
    chk("midrst_quo", {24'd0, q8}, 32'd0);
    chk("midrst_rem", {24'd0, r8}, 32'd0);
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_result", {31'd0, rv8}, 32'd0);
    end
    rr8 = 1'b0;
    run8(8'd100, 8'd10, 1'b0, 0);

    // A request withdrawn while not accepted leaves nothing behind
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; vld8 = 1'b0;
    @(negedge clk);
    chk("no_accept_rdy", {31'd0, rdy8}, 32'd1);

    // Random operations on the N=8 instance
    for (int i = 0; i < 120; i++) begin
      run8(8'($urandom), (i % 16 == 0) ? 8'd0 : 8'($urandom), 1'($urandom),
           int'($urandom_range(0, 2)));
    end

    // Exhaustive N=4 with random result stalls
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          run4(4'(ia), 4'(ib), s[0], int'($urandom_range(0, 2)));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
